// File: rtl/pe_dot_pkg.sv
// Shared types and constants for the PE dot-product driver.
package pe_dot_pkg;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 13;

   // Q2.13 reference constants (1.0 and 0.5).
   localparam logic [DATA_W-1:0] ONE  = 16'h2000;
   localparam logic [DATA_W-1:0] HALF = 16'h1000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE    = 3'd1,
      WAIT_MUL = 3'd2,
      WAIT_OUT = 3'd3,
      DONE     = 3'd4
   } state_t;
endpackage

// File: rtl/pe_dot_driver_if.sv
// Loader/PE/status bundle of the dot-product driver.
// master = the driver itself, slave = loader + PE + status consumer.
interface pe_dot_driver_if
   import pe_dot_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
);
   logic              I_LD_VLD;
   logic [DATA_W-1:0] I_LD_X;
   logic [DATA_W-1:0] I_LD_W;
   logic              I_CLR;
   logic              I_START;
   logic [AW:0]       I_LEN;
   logic              O_PE_X_VLD;
   logic [DATA_W-1:0] O_PE_X;
   logic              O_PE_W_VLD;
   logic [DATA_W-1:0] O_PE_W;
   logic              O_PE_D_VLD;
   logic [DATA_W-1:0] O_PE_D;
   logic              I_PE_MUL_DONE;
   logic              I_PE_OUT_VLD;
   logic [DATA_W-1:0] I_PE_OUT;
   logic              O_BUSY;
   logic              O_DONE;
   logic [DATA_W-1:0] O_SUM;
   logic              O_ERR;

   modport master (
      input  I_LD_VLD, I_LD_X, I_LD_W, I_CLR, I_START, I_LEN,
      input  I_PE_MUL_DONE, I_PE_OUT_VLD, I_PE_OUT,
      output O_PE_X_VLD, O_PE_X, O_PE_W_VLD, O_PE_W, O_PE_D_VLD, O_PE_D,
      output O_BUSY, O_DONE, O_SUM, O_ERR
   );

   modport slave (
      output I_LD_VLD, I_LD_X, I_LD_W, I_CLR, I_START, I_LEN,
      output I_PE_MUL_DONE, I_PE_OUT_VLD, I_PE_OUT,
      input  O_PE_X_VLD, O_PE_X, O_PE_W_VLD, O_PE_W, O_PE_D_VLD, O_PE_D,
      input  O_BUSY, O_DONE, O_SUM, O_ERR
   );
endinterface

// File: rtl/pe_dot_buf.sv
// (x, w) pair buffer: one write port, one registered read port with enable.
// The read register doubles as the PE X/W output register, so it is reset.
module pe_dot_buf
   import pe_dot_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_w,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_x,
   output logic [DATA_W-1:0] o_w
);
   logic [2*DATA_W-1:0] r_mem [DEPTH];
   logic [2*DATA_W-1:0] r_rd;

   // Store one pair per write strobe; contents survive runs.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= {i_x, i_w};
      end
   end

   // Registered read, only refreshed when a new pair is about to be issued.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd <= '0;
      end else if (i_re) begin
         r_rd <= r_mem[i_raddr];
      end
   end

   assign o_x = r_rd[2*DATA_W-1:DATA_W];
   assign o_w = r_rd[DATA_W-1:0];
endmodule

// File: rtl/pe_dot_driver.sv
// PE dot-product driver: buffers up to DEPTH (x, w) pairs, streams them one
// pair at a time into a single PE MAC and feeds each PE result back as the
// next partial sum. All outputs are registered.
module pe_dot_driver
   import pe_dot_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int AW      = $clog2(DEPTH),
   parameter int TIMEOUT = 64
) (
   input  logic            I_CLK,
   input  logic            I_RST,
   pe_dot_driver_if.master bus
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW:0]   L_DEPTH   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] L_IDX_ONE = AW'(1);
   localparam logic [TW-1:0] L_TMO_ONE = TW'(1);
   localparam logic [TW-1:0] L_TMO_MAX = TW'(TIMEOUT - 1);

   state_t            r_state, w_state_nxt;
   logic [AW:0]       r_cnt, w_cnt_nxt;
   logic [AW:0]       r_len, w_len_nxt;
   logic [AW-1:0]     r_idx, w_idx_nxt;
   logic [DATA_W-1:0] r_acc, w_acc_nxt;
   logic [TW-1:0]     r_tmo, w_tmo_nxt;
   logic              w_we, w_err, w_start_ok, w_last;
   logic              r_x_vld, r_d_vld, r_busy, r_done, r_err;
   logic [DATA_W-1:0] r_pe_d, r_sum;
   logic [DATA_W-1:0] w_buf_x, w_buf_w;

   assign w_start_ok = !bus.I_LD_VLD && !bus.I_CLR && (bus.I_LEN != '0) && (bus.I_LEN <= r_cnt);
   assign w_last     = (({1'b0, r_idx} + L_CNT_ONE) == r_len);

   // Next state, load/start arbitration, index, accumulator and timeout updates.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_idx_nxt   = r_idx;
      w_acc_nxt   = r_acc;
      w_tmo_nxt   = r_tmo;
      w_we        = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.I_CLR) begin
               w_cnt_nxt = '0;
            end else if (bus.I_LD_VLD && (r_cnt < L_DEPTH)) begin
               w_we      = 1'b1;
               w_cnt_nxt = r_cnt + L_CNT_ONE;
            end else begin
               w_cnt_nxt = r_cnt;
            end
            if (bus.I_START && w_start_ok) begin
               w_len_nxt   = bus.I_LEN;
               w_idx_nxt   = '0;
               w_acc_nxt   = '0;
               w_state_nxt = ISSUE;
            end else if (bus.I_START) begin
               w_err = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ISSUE: begin
            w_state_nxt = WAIT_MUL;
            w_tmo_nxt   = '0;
         end
         WAIT_MUL: begin
            if (bus.I_PE_MUL_DONE) begin
               w_state_nxt = WAIT_OUT;
               w_tmo_nxt   = '0;
            end else if (r_tmo == L_TMO_MAX) begin
               w_err       = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_tmo_nxt = r_tmo + L_TMO_ONE;
            end
         end
         WAIT_OUT: begin
            if (bus.I_PE_OUT_VLD) begin
               w_acc_nxt = bus.I_PE_OUT;
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt   = r_idx + L_IDX_ONE;
                  w_state_nxt = ISSUE;
               end
            end else if (r_tmo == L_TMO_MAX) begin
               w_err       = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_tmo_nxt = r_tmo + L_TMO_ONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath registers and registered outputs derived from the next state.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
         r_tmo   <= '0;
         r_x_vld <= 1'b0;
         r_d_vld <= 1'b0;
         r_pe_d  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_idx   <= w_idx_nxt;
         r_acc   <= w_acc_nxt;
         r_tmo   <= w_tmo_nxt;
         r_x_vld <= (w_state_nxt == ISSUE);
         r_d_vld <= (w_state_nxt == WAIT_MUL);
         if (r_state == ISSUE) begin
            r_pe_d <= r_acc;
         end
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (w_state_nxt == DONE);
         if (w_state_nxt == DONE) begin
            r_sum <= w_acc_nxt;
         end
         r_err   <= w_err;
      end
   end

   // The read address is the next index, so data is ready in the ISSUE cycle.
   pe_dot_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .i_clk   (I_CLK),
      .i_rst   (I_RST),
      .i_we    (w_we),
      .i_waddr (r_cnt[AW-1:0]),
      .i_x     (bus.I_LD_X),
      .i_w     (bus.I_LD_W),
      .i_re    (w_state_nxt == ISSUE),
      .i_raddr (w_idx_nxt),
      .o_x     (w_buf_x),
      .o_w     (w_buf_w)
   );

   assign bus.O_PE_X_VLD = r_x_vld;
   assign bus.O_PE_W_VLD = r_x_vld;
   assign bus.O_PE_X     = w_buf_x;
   assign bus.O_PE_W     = w_buf_w;
   assign bus.O_PE_D_VLD = r_d_vld;
   assign bus.O_PE_D     = r_pe_d;
   assign bus.O_BUSY     = r_busy;
   assign bus.O_DONE     = r_done;
   assign bus.O_SUM      = r_sum;
   assign bus.O_ERR      = r_err;
endmodule
